// File: rtl/pc_fetch_seq.sv
// Fetch PC register and instruction-fetch sequencer with a one-entry stall buffer.
// Also owns the EPC / in-exception state consumed by the next-PC adder.
module pc_fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        siic,
    input  logic [15:0] epc_src,
    input  logic        rti,
    input  logic        halt,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        fetch_valid,
    output logic [15:0] fetch_instr,
    output logic [15:0] fetch_pc_plus2,
    output logic [15:0] epc_value,
    output logic        in_exception,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] epc_q, epc_d;
    logic        in_exc_q, in_exc_d;
    logic        err_q, err_d;
    logic [15:0] pc_plus2;

    assign pc_plus2     = pc_q + 16'd2;
    assign imem_addr    = pc_q;
    assign epc_value    = epc_q;
    assign in_exception = in_exc_q;
    assign halted       = (state_q == StHalt);
    assign err          = err_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        imem_req       = 1'b0;
        fetch_valid    = 1'b0;
        fetch_instr    = 16'h0000;
        fetch_pc_plus2 = 16'h0000;
        // Outputs are forced quiet during reset; the register block does the clearing.
        if (rst_n && state_q != StHalt) begin
            if (halt) begin
                state_d = StHalt;
            end else if (redirect_valid) begin
                pc_d    = redirect_pc;
                hold_d  = 16'h0000;
                state_d = StFetch;
            end else begin
                unique case (state_q)
                    StFetch: begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            pc_d = pc_plus2;
                            if (!stall) begin
                                fetch_valid    = 1'b1;
                                fetch_instr    = imem_data;
                                fetch_pc_plus2 = pc_plus2;
                            end else begin
                                hold_d  = imem_data;
                                state_d = StHold;
                            end
                        end
                    end
                    StHold: begin
                        // pc already advanced past the held instruction
                        fetch_valid    = 1'b1;
                        fetch_instr    = hold_q;
                        fetch_pc_plus2 = pc_q;
                        if (!stall) begin
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // Illegal siic/rti combinations leave exception state untouched and flag err.
    always_comb begin
        epc_d    = epc_q;
        in_exc_d = in_exc_q;
        err_d    = 1'b0;
        if (siic && rti) begin
            err_d = 1'b1;
        end else if (siic) begin
            if (in_exc_q) begin
                err_d = 1'b1;
            end else begin
                epc_d    = epc_src;
                in_exc_d = 1'b1;
            end
        end else if (rti) begin
            if (!in_exc_q) begin
                err_d = 1'b1;
            end else begin
                in_exc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            hold_q   <= 16'h0000;
            epc_q    <= 16'h0000;
            in_exc_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            epc_q    <= epc_d;
            in_exc_q <= in_exc_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: a driver feeds a behavioural model that queues
// expected per-cycle status and expected delivered instructions; a monitor checks them.
module tb_pc_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        siic;
    logic [15:0] epc_src;
    logic        rti;
    logic        halt;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc_plus2;
    logic [15:0] epc_value;
    logic        in_exception;
    logic        halted;
    logic        err;

    pc_fetch_seq #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .siic           (siic),
        .epc_src        (epc_src),
        .rti            (rti),
        .halt           (halt),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc_plus2 (fetch_pc_plus2),
        .epc_value      (epc_value),
        .in_exception   (in_exception),
        .halted         (halted),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        known;
        logic        req;
        logic [15:0] addr;
        logic        fv;
        logic [15:0] epc;
        logic        inexc;
        logic        halted;
        logic        err;
    } status_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] plus2;
    } fetch_t;

    status_t status_q[$];
    fetch_t  fetch_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural PC, a list of held instructions, and flags.
    logic        m_known = 1'b0;
    logic [15:0] m_pc;
    logic [15:0] m_held[$];
    logic        m_halted;
    logic [15:0] m_epc;
    logic        m_inexc;
    logic        m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic a_rst_n, input logic a_halt, input logic a_rv,
                        input logic [15:0] a_rpc, input logic a_siic, input logic [15:0] a_epcs,
                        input logic a_rti, input logic a_stall, input logic a_ready,
                        input logic [15:0] a_data);
        status_t     s;
        fetch_t      f;
        logic [15:0] n_pc;
        logic        bad;
        rst_n          = a_rst_n;
        halt           = a_halt;
        redirect_valid = a_rv;
        redirect_pc    = a_rpc;
        siic           = a_siic;
        epc_src        = a_epcs;
        rti            = a_rti;
        stall          = a_stall;
        imem_ready     = a_ready;
        imem_data      = a_data;

        s.known  = m_known;
        s.req    = 1'b0;
        s.addr   = m_pc;
        s.fv     = 1'b0;
        s.epc    = m_epc;
        s.inexc  = m_inexc;
        s.halted = m_halted;
        s.err    = m_err;

        if (!a_rst_n) begin
            m_known  = 1'b1;
            m_pc     = 16'h0000;
            m_held   = {};
            m_halted = 1'b0;
            m_epc    = 16'h0000;
            m_inexc  = 1'b0;
            m_err    = 1'b0;
        end else begin
            bad = (a_siic && a_rti) || (a_siic && m_inexc) || (a_rti && !m_inexc);
            if (!bad && a_siic) begin
                m_epc   = a_epcs;
                m_inexc = 1'b1;
            end else if (!bad && a_rti) begin
                m_inexc = 1'b0;
            end
            m_err = bad;
            if (m_halted) begin
                // stays halted until reset
            end else if (a_halt) begin
                m_halted = 1'b1;
            end else if (a_rv) begin
                m_pc   = a_rpc;
                m_held = {};
            end else if (m_held.size() > 0) begin
                s.fv    = 1'b1;
                f.instr = m_held[0];
                f.plus2 = m_pc;
                fetch_q.push_back(f);
                if (!a_stall) void'(m_held.pop_front());
            end else begin
                s.req = 1'b1;
                if (a_ready) begin
                    n_pc = m_pc + 16'd2;
                    if (!a_stall) begin
                        s.fv    = 1'b1;
                        f.instr = a_data;
                        f.plus2 = n_pc;
                        fetch_q.push_back(f);
                    end else begin
                        m_held.push_back(a_data);
                    end
                    m_pc = n_pc;
                end
            end
        end
        status_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic a_ready, input logic a_stall, input logic [15:0] a_data);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, a_stall, a_ready, a_data);
    endtask

    task automatic redir(input logic [15:0] pc, input logic a_siic, input logic [15:0] epcs,
                         input logic a_rti, input logic a_stall);
        step(1'b1, 1'b0, 1'b1, pc, a_siic, epcs, a_rti, a_stall, 1'b1, 16'h5A5A);
    endtask

    // Monitor: status every cycle, delivered instructions whenever fetch_valid is seen.
    always @(negedge clk) begin
        status_t s;
        fetch_t  f;
        if (status_q.size() > 0) begin
            s = status_q.pop_front();
            chk("imem_req", {15'h0, imem_req}, {15'h0, s.req});
            chk("fetch_valid", {15'h0, fetch_valid}, {15'h0, s.fv});
            if (s.req) chk("imem_addr", imem_addr, s.addr);
            if (s.known) begin
                chk("epc_value", epc_value, s.epc);
                chk("in_exception", {15'h0, in_exception}, {15'h0, s.inexc});
                chk("halted", {15'h0, halted}, {15'h0, s.halted});
                chk("err", {15'h0, err}, {15'h0, s.err});
            end
        end
        if (fetch_valid === 1'b1) begin
            if (fetch_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fetch_unexpected at %0t: got instr %h expected none",
                         $time, fetch_instr);
            end else begin
                f = fetch_q.pop_front();
                chk("fetch_instr", fetch_instr, f.instr);
                chk("fetch_pc_plus2", fetch_pc_plus2, f.plus2);
            end
        end
    end

    initial begin
        logic r_rst, r_halt, r_rv, r_siic, r_rti, r_stall, r_ready;
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        siic = 1'b0; epc_src = 16'h0; rti = 1'b0; stall = 1'b0;
        imem_ready = 1'b0; imem_data = 16'h0;
        m_pc = 16'h0; m_halted = 1'b0; m_epc = 16'h0; m_inexc = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;

        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2222);
        for (int i = 0; i < 4; i++) fetch(1'b1, 1'b0, 16'h1000 + 16'(i));
        fetch(1'b0, 1'b0, 16'hDEAD);

        // stall with data held, then release and resume at 0x0012
        redir(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0);
        fetch(1'b1, 1'b1, 16'hABCD);
        fetch(1'b1, 1'b1, 16'h0BAD);
        fetch(1'b1, 1'b1, 16'h0BAD);
        fetch(1'b1, 1'b0, 16'h0BAD);
        fetch(1'b1, 1'b0, 16'h3333);

        // SIIC / RTI round trip and protocol errors
        redir(16'h0002, 1'b1, 16'h0104, 1'b0, 1'b0);
        fetch(1'b1, 1'b0, 16'h4444);
        redir(16'h0008, 1'b1, 16'h0200, 1'b0, 1'b0);
        fetch(1'b1, 1'b0, 16'h4445);
        fetch(1'b1, 1'b0, 16'h4446);
        redir(16'h0104, 1'b0, 16'h0, 1'b1, 1'b0);
        fetch(1'b1, 1'b0, 16'h5555);
        redir(16'h0020, 1'b0, 16'h0, 1'b1, 1'b0);
        fetch(1'b1, 1'b0, 16'h5556);
        redir(16'h0030, 1'b1, 16'h0300, 1'b1, 1'b0);
        fetch(1'b1, 1'b0, 16'h5557);

        // halt wins over redirect; only reset leaves HALT
        step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h6666);
        for (int i = 0; i < 3; i++) fetch(1'b1, 1'b0, 16'h6667);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777);
        fetch(1'b1, 1'b0, 16'h7778);
        fetch(1'b1, 1'b0, 16'h7779);

        // PC wrap and redirect during HOLD
        redir(16'hFFFE, 1'b0, 16'h0, 1'b0, 1'b0);
        fetch(1'b1, 1'b0, 16'h8888);
        fetch(1'b1, 1'b0, 16'h8889);
        fetch(1'b1, 1'b1, 16'h9999);
        redir(16'h0081, 1'b0, 16'h0, 1'b0, 1'b1);
        fetch(1'b1, 1'b0, 16'hAAAA);
        fetch(1'b1, 1'b0, 16'hAAAB);

        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 99) != 0);
            r_halt  = ($urandom_range(0, 149) == 0);
            r_rv    = ($urandom_range(0, 9) == 0);
            r_siic  = ($urandom_range(0, 19) == 0);
            r_rti   = ($urandom_range(0, 19) == 0);
            r_stall = ($urandom_range(0, 9) < 3);
            r_ready = ($urandom_range(0, 9) < 7);
            step(r_rst, r_halt, r_rv, 16'($urandom), r_siic, 16'($urandom), r_rti,
                 r_stall, r_ready, 16'($urandom));
        end

        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        #1;
        chk("fetch_queue_drained", 16'(fetch_q.size()), 16'h0);
        chk("status_queue_drained", 16'(status_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

PC register, instruction-fetch sequencer and EPC owner for the 16-bit pipelined core. It holds the architectural fetch PC and issues word fetches to instruction memory. It buffers one returned instruction across a decode stall and accepts the redirect PC computed by the next-PC adder. It also owns the EPC/exception state that the adder consumes when it produces 0x0002 (SIIC) or EPC (RTI) targets.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect_valid  in  1  taken branch/jump/SIIC/RTI resolved this cycle.
- redirect_pc  in  16  target from the next-PC adder; valid with redirect_valid.
- siic  in  1  SIIC commits this cycle; qualifies redirect_valid.
- epc_src  in  16  PC+2 of the excepting instruction; sampled with siic.
- rti  in  1  RTI commits this cycle; qualifies redirect_valid.
- halt  in  1  HALT commits; fetch stops permanently.
- stall  in  1  decode cannot accept an instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; equals PC.
- imem_ready  in  1  imem_data valid for imem_addr this cycle.
- imem_data  in  16  returned instruction.
- fetch_valid  out  1  fetch_instr/fetch_pc_plus2 valid to decode.
- fetch_instr  out  16  instruction to decode.
- fetch_pc_plus2  out  16  PC+2 of fetch_instr.
- epc_value  out  16  saved EPC, to next-PC adder.
- in_exception  out  1  inside SIIC handler.
- halted  out  1  HALT state.
- err  out  1  registered one-cycle protocol-error pulse.

## Operation
- States: FETCH, HOLD, HALT. Reset → FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - If imem_ready=0: stay; pc and addr are stable.
  - If imem_ready=1 and stall=0: fetch_valid=1 combinationally, fetch_instr=imem_data, fetch_pc_plus2=pc+2; pc←pc+2.
  - If imem_ready=1 and stall=1: hold_instr←imem_data; pc←pc+2; → HOLD.
- HOLD:
  - imem_req=0, fetch_valid=1, fetch_instr=hold_instr, fetch_pc_plus2=pc (already advanced).
  - stall=0 → FETCH. The next fetch request is issued the following cycle.
- HALT:
  - imem_req=0, fetch_valid=0, halted=1.
  - Exits only on reset.
- Redirect (redirect_valid=1, state ≠ HALT):
  - pc←redirect_pc; the hold buffer is discarded; → FETCH.
  - imem_req=0 and fetch_valid=0 in that cycle, so no in-flight accept.
- Priority: rst_n low > halt > redirect_valid > normal fetch.
- Arithmetic: pc+2 is 16-bit modulo. 0xFFFE advances to 0x0000 with no flag. Bit 0 of redirect_pc is passed through unmodified.
- SIIC (siic=1, in_exception=0):
  - epc←epc_src and in_exception←1.
  - siic without redirect_valid still updates EPC.
- RTI (rti=1, in_exception=1): in_exception←0. epc is retained.
- Errors:
  - siic with in_exception=1: EPC unchanged, err=1 next cycle.
  - rti with in_exception=0: err=1 next cycle.
  - siic and rti in the same cycle: both ignored, err=1 next cycle.
  - The redirect is still taken in all three cases.

## Timing
- Reset values: pc=RESET_PC, epc=0, in_exception=0, halted=0, err=0, hold_instr=0, state=FETCH.
- imem_req=0 and fetch_valid=0 while rst_n=0.
- First request is in the first cycle with rst_n=1.
- Fetch latency: zero cycles from imem_ready to fetch_valid in FETCH. Sustained throughput is one instruction per cycle with imem_ready held high and stall=0.
- Stall recovery: a 1-cycle bubble after HOLD exits.
- Redirect: target on imem_addr the cycle after redirect_valid.
- EPC/in_exception/err/halted are registered and visible the cycle after their cause.
- Reset asserted mid-HOLD or mid-HALT returns to FETCH at RESET_PC with the hold buffer cleared.

## Test plan
- Reset, then imem_ready=1, stall=0 for 4 cycles → imem_addr 0x0000, 0x0002, 0x0004, 0x0006; fetch_pc_plus2 0x0002…0x0008.
- pc=0x0010, imem_ready=1 with stall=1 for 3 cycles, data 0xABCD → HOLD; fetch_instr=0xABCD, fetch_pc_plus2=0x0012 throughout, imem_req=0; after stall drops, next request is at 0x0012.
- siic with epc_src=0x0104, redirect_pc=0x0002 → next cycle epc_value=0x0104, in_exception=1, imem_addr=0x0002; later rti with redirect_pc=0x0104 → in_exception=0, imem_addr=0x0104.
- Second siic while in_exception=1 → err pulses once, epc_value stays 0x0104. rti with in_exception=0 → err pulses once.
- halt and redirect_valid in the same cycle → halted=1, imem_req=0 forever, pc unchanged; rst_n low for one cycle → FETCH at 0x0000.
- pc=0xFFFE accepted → next imem_addr=0x0000. Redirect during HOLD → hold buffer dropped, fetch_valid=0 that cycle, fetch resumes at redirect_pc.
